calc_cmd_sequencer: RTL and testbench

//  Turns the board's synchronized switches and buttons into single calculator commands.

---
 rtl/calc_pkg.sv | 17 +
 rtl/btn_debounce.sv | 33 +++
 rtl/calc_cmd_sequencer.sv | 80 ++++++++
 tb/tb_calc_cmd_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: command and arithmetic op codes shared between the sequencer and the calc core
package calc_pkg;
  localparam int ARG_W_DEF = 32;
  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_PUSH  = 3'd1,
    CMD_OP    = 3'd2,
    CMD_POP   = 3'd3,
    CMD_CLEAR = 3'd4
  } cmd_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3
  } arith_e;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: takes the raw level only after it has disagreed for CYCLES cycles, flags 0->1
module btn_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          clean_q;
  logic          rise_q;
  // disagreement counter; it never exceeds CYCLES, so it cannot wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (raw == clean_q) cnt_q <= '0;
      else if (cnt_q == CW'(CYCLES)) begin
        cnt_q   <= '0;
        clean_q <= raw;
        rise_q  <= raw;
      end else cnt_q <= cnt_q + CW'(1);
    end
  end
  assign clean = clean_q;
  assign rise  = rise_q;
endmodule

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: debounced button presses become single handshaked calc commands
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DONE_TIMEOUT    = 1024,
  parameter int ARG_W           = ARG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sw,
  input  logic [3:0]       btn,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_op,
  output logic [ARG_W-1:0] cmd_arg,
  input  logic             cmd_done,
  output logic             busy,
  output logic             timeout_err
);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_e;
  state_e           state_q;
  cmd_e             op_q;
  logic [ARG_W-1:0] arg_q;
  logic [TW-1:0]    tcnt_q;
  logic             valid_q;
  logic             terr_q;
  logic [3:0]       clean;
  logic [3:0]       rise;
  for (genvar g = 0; g < 4; g++) begin : g_db
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn[g]),
      .clean(clean[g]),
      .rise (rise[g])
    );
  end
  // command FSM: latch on press, offer until accepted, wait for done, then wait for release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= CMD_NOP;
      arg_q   <= '0;
      tcnt_q  <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|rise) begin
          state_q <= ISSUE;
          valid_q <= 1'b1;
          op_q    <= rise[0] ? CMD_PUSH : rise[1] ? CMD_OP : rise[2] ? CMD_POP : CMD_CLEAR;
          arg_q   <= rise[0] ? ARG_W'(sw) : '0;
        end
        ISSUE: if (cmd_ready) begin
          valid_q <= 1'b0;
          tcnt_q  <= '0;
          state_q <= cmd_done ? RELEASE : WAIT;
          if (cmd_done && op_q == CMD_CLEAR) terr_q <= 1'b0;
        end
        WAIT: if (cmd_done) begin
          state_q <= RELEASE;
          if (op_q == CMD_CLEAR) terr_q <= 1'b0;
        end else if (tcnt_q == TW'(DONE_TIMEOUT - 1)) begin
          state_q <= RELEASE;
          terr_q  <= 1'b1;
        end else tcnt_q <= tcnt_q + TW'(1);
        RELEASE: if (~|clean) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cmd_valid   = valid_q;
  assign cmd_op      = op_q;
  assign cmd_arg     = arg_q;
  assign busy        = state_q != IDLE;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb_calc_cmd_sequencer: directed vectors with hand-computed expectations
module tb_calc_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sw = '0;
  logic [3:0]  btn = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_done = 1'b0;
  logic        busy;
  logic        timeout_err;
  int          n_chk = 0;
  int          n_pass = 0;

  calc_cmd_sequencer #(.DEBOUNCE_CYCLES(4), .DONE_TIMEOUT(8), .ARG_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .btn        (btn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .cmd_done   (cmd_done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!cmd_valid && n < 30) begin
      step();
      n++;
    end
    chk("valid_seen", cmd_valid, 1);
  endtask

  task automatic wait_idle(output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (busy && n < 30) begin
      step();
      n++;
      if (cmd_valid) pulses++;
    end
    chk("idle_reached", busy, 0);
  endtask

  int  n, pulses;
  logic stable;

  initial begin
    step();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op", cmd_op, 0);
    chk("rst_arg", cmd_arg, 0);
    chk("rst_terr", timeout_err, 0);
    step();
    // 1: PUSH of 0x5A
    rst = 1'b0;
    sw = 8'h5A;
    btn = 4'b0001;
    cmd_ready = 1'b1;
    wait_valid(n);
    chk("t1_latency", n, 6);
    chk("t1_op", cmd_op, 1);
    chk("t1_arg", cmd_arg, 32'h0000005A);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_valid_drop", cmd_valid, 0);
    step();
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    step();
    btn = 4'b0000;
    chk("t1_busy_held", busy, 1);
    wait_idle(n, pulses);
    chk("t1_release_cycles", n, 6);
    chk("t1_no_extra_valid", pulses, 0);
    // 2: bouncing button never issues
    pulses = 0;
    for (int i = 0; i < 22; i++) begin
      btn[0] = (i < 12) && ((i / 2) % 2 == 0);
      step();
      if (cmd_valid) pulses++;
    end
    chk("t2_no_valid", pulses, 0);
    chk("t2_busy", busy, 0);
    // 3: simultaneous btn1+btn2 -> OP only
    sw = 8'h03;
    btn = 4'b0110;
    wait_valid(n);
    chk("t3_op", cmd_op, 2);
    chk("t3_arg", cmd_arg, 0);
    step();
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    step();
    btn = 4'b0000;
    wait_idle(n, pulses);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cmd_valid) pulses++;
    end
    chk("t3_no_pop", pulses, 0);
    // 4: stalled calc, command held stable
    cmd_ready = 1'b0;
    sw = 8'h33;
    btn = 4'b0001;
    wait_valid(n);
    sw = 8'hFF;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!cmd_valid || cmd_op != 3'd1 || cmd_arg != 32'h33 || timeout_err) stable = 1'b0;
    end
    chk("t4_stable", stable, 1);
    cmd_ready = 1'b1;
    step();
    chk("t4_handshake", cmd_valid, 0);
    chk("t4_busy", busy, 1);
    // 5: timeout 8 cycles after handshake, then CLEAR recovers
    for (int i = 0; i < 7; i++) step();
    chk("t5_terr_early", timeout_err, 0);
    step();
    chk("t5_terr_set", timeout_err, 1);
    btn = 4'b0000;
    wait_idle(n, pulses);
    btn = 4'b1000;
    wait_valid(n);
    chk("t5_clear_op", cmd_op, 4);
    step();
    chk("t5_terr_held", timeout_err, 1);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    chk("t5_terr_cleared", timeout_err, 0);
    btn = 4'b0000;
    wait_idle(n, pulses);
    // 6: async reset mid-WAIT, late done ignored
    sw = 8'h77;
    btn = 4'b0001;
    wait_valid(n);
    step();
    chk("t6_in_wait", busy, 1);
    rst = 1'b1;
    btn = 4'b0000;
    #1;
    chk("t6_rst_valid", cmd_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_op", cmd_op, 0);
    chk("t6_rst_arg", cmd_arg, 0);
    step();
    rst = 1'b0;
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cmd_valid || busy) pulses++;
    end
    chk("t6_late_done_ignored", pulses, 0);
    chk("t6_terr", timeout_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
